// File: rtl/tomasulo_dispatch_unit.sv
// Single-issue dispatch stage that resolves operands to a value or a producing-ALU tag.
// It allows one outstanding result per ALU and picks a free ALU round-robin.
module tomasulo_dispatch_unit #(
  parameter int DATA_WIDTH          = 32,
  parameter int PHYS_REG_ADDR_WIDTH = 6,
  parameter int ARCH_REGS           = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4:0]                     in_rs1,
  input  logic [4:0]                     in_rs2,
  input  logic [4:0]                     in_rd,
  input  logic                           in_rd_write,
  input  logic                           in_use_imm,
  input  logic [DATA_WIDTH-1:0]          in_imm,
  input  logic                           in_is_store,
  input  logic [10:0]                    in_control_signals,
  input  logic [DATA_WIDTH-1:0]          in_pc,
  input  logic [DATA_WIDTH-1:0]          in_pc_value_at_prediction,
  input  logic [2:0]                     in_branch_sel,
  input  logic                           in_branch_prediction,
  output logic [2:0]                     rs_dispatch_valid,
  input  logic [2:0]                     rs_dispatch_ready,
  output logic [DATA_WIDTH-1:0]          out_operand_a_data,
  output logic [DATA_WIDTH-1:0]          out_operand_b_data,
  output logic [DATA_WIDTH-1:0]          out_store_data,
  output logic [1:0]                     out_operand_a_tag,
  output logic [1:0]                     out_operand_b_tag,
  output logic [PHYS_REG_ADDR_WIDTH-1:0] out_rd_phys_addr,
  output logic [10:0]                    out_control_signals,
  output logic [DATA_WIDTH-1:0]          out_pc,
  output logic [DATA_WIDTH-1:0]          out_pc_value_at_prediction,
  output logic [2:0]                     out_branch_sel,
  output logic                           out_branch_prediction,
  input  logic                           cdb_valid_0,
  input  logic                           cdb_valid_1,
  input  logic                           cdb_valid_2,
  input  logic [DATA_WIDTH-1:0]          cdb_data_0,
  input  logic [DATA_WIDTH-1:0]          cdb_data_1,
  input  logic [DATA_WIDTH-1:0]          cdb_data_2
);
  localparam logic [1:0] TAG_READY = 2'b11;

  logic [DATA_WIDTH-1:0] r_value [ARCH_REGS];
  logic [1:0]            r_tag   [ARCH_REGS];
  logic [2:0]            r_outstanding;
  logic [1:0]            r_rr_ptr;

  // Fourth slot is a dead entry so a ready tag (11) can index these safely.
  logic [3:0]            w_cdb_valid;
  logic [DATA_WIDTH-1:0] w_cdb_data [4];
  logic [3:0]            w_elig;
  logic [2:0]            w_sum  [3];
  logic [1:0]            w_scan [3];
  logic [1:0]            w_sel;
  logic [1:0]            w_rr_next;
  logic                  w_any;
  logic                  w_store_ok;
  logic                  w_accept;
  logic [1:0]            w_rs1_tag, w_rs2_tag;
  logic [1:0]            w_a_tag, w_r2_tag;
  logic [DATA_WIDTH-1:0] w_a_data, w_r2_data;

  assign w_cdb_valid   = {1'b0, cdb_valid_2, cdb_valid_1, cdb_valid_0};
  assign w_cdb_data[0] = cdb_data_0;
  assign w_cdb_data[1] = cdb_data_1;
  assign w_cdb_data[2] = cdb_data_2;
  assign w_cdb_data[3] = '0;

  function automatic logic [DATA_WIDTH+1:0] f_resolve(
    input logic [1:0]            tag,
    input logic [DATA_WIDTH-1:0] value,
    input logic                  cdb_hit,
    input logic [DATA_WIDTH-1:0] cdb_value
  );
    if (tag == TAG_READY) return {TAG_READY, value};
    if (cdb_hit)          return {TAG_READY, cdb_value};
    return {tag, {DATA_WIDTH{1'b0}}};
  endfunction

  assign w_rs1_tag = r_tag[in_rs1];
  assign w_rs2_tag = r_tag[in_rs2];
  assign {w_a_tag, w_a_data}   = f_resolve(w_rs1_tag, r_value[in_rs1],
                                           w_cdb_valid[w_rs1_tag], w_cdb_data[w_rs1_tag]);
  assign {w_r2_tag, w_r2_data} = f_resolve(w_rs2_tag, r_value[in_rs2],
                                           w_cdb_valid[w_rs2_tag], w_cdb_data[w_rs2_tag]);

  // A busy ALU becomes reusable in the same cycle its result is broadcast.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_alu
      assign w_elig[gi] = rs_dispatch_ready[gi] && (!r_outstanding[gi] || w_cdb_valid[gi]);
      assign w_sum[gi]  = {1'b0, r_rr_ptr} + 3'(gi);
      assign w_scan[gi] = (w_sum[gi] >= 3'd3) ? 2'(w_sum[gi] - 3'd3) : w_sum[gi][1:0];
    end
  endgenerate
  assign w_elig[3] = 1'b0;

  always_comb begin
    w_sel = 2'd0;
    w_any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!w_any && w_elig[w_scan[i]]) begin
        w_any = 1'b1;
        w_sel = w_scan[i];
      end
    end
  end

  assign w_rr_next  = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
  assign w_store_ok = !in_is_store || (w_r2_tag == TAG_READY);
  assign in_ready   = w_any && w_store_ok;
  assign w_accept   = in_valid && in_ready;

  assign rs_dispatch_valid          = w_accept ? (3'b001 << w_sel) : 3'b000;
  assign out_operand_a_data         = w_a_data;
  assign out_operand_a_tag          = w_a_tag;
  assign out_operand_b_data         = in_use_imm ? in_imm : w_r2_data;
  assign out_operand_b_tag          = in_use_imm ? TAG_READY : w_r2_tag;
  assign out_store_data             = w_r2_data;
  assign out_rd_phys_addr           = PHYS_REG_ADDR_WIDTH'(in_rd);
  assign out_control_signals        = in_control_signals;
  assign out_pc                     = in_pc;
  assign out_pc_value_at_prediction = in_pc_value_at_prediction;
  assign out_branch_sel             = in_branch_sel;
  assign out_branch_prediction      = in_branch_prediction;

  // Entry 0 is only ever reset, so x0 stays at value 0 / ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ARCH_REGS; r++) begin
        r_value[r] <= '0;
        r_tag[r]   <= TAG_READY;
      end
      r_outstanding <= 3'b000;
      r_rr_ptr      <= 2'd0;
    end else begin
      for (int r = 1; r < ARCH_REGS; r++) begin
        for (int k = 0; k < 3; k++) begin
          if (w_cdb_valid[k] && r_tag[r] == 2'(k)) begin
            r_value[r] <= w_cdb_data[k];
            r_tag[r]   <= TAG_READY;
          end
        end
        if (w_accept && in_rd_write && in_rd == 5'(r)) r_tag[r] <= w_sel;
      end
      for (int k = 0; k < 3; k++) begin
        if (w_cdb_valid[k]) r_outstanding[k] <= 1'b0;
        if (w_accept && w_sel == 2'(k)) r_outstanding[k] <= 1'b1;
      end
      if (w_accept) r_rr_ptr <= w_rr_next;
    end
  end
endmodule

// File: tb/tb_tomasulo_dispatch_unit.sv
// Directed scoreboard bench for tomasulo_dispatch_unit: stimulus queues expected
// dispatches, a negedge monitor pops and compares whenever the DUT strobes an RS.
module tb_tomasulo_dispatch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_write, in_use_imm, in_is_store;
  logic [31:0] in_imm, in_pc, in_pc_value_at_prediction;
  logic [10:0] in_control_signals;
  logic [2:0]  in_branch_sel;
  logic        in_branch_prediction;
  logic [2:0]  rs_dispatch_valid, rs_dispatch_ready;
  logic [31:0] out_operand_a_data, out_operand_b_data, out_store_data;
  logic [1:0]  out_operand_a_tag, out_operand_b_tag;
  logic [5:0]  out_rd_phys_addr;
  logic [10:0] out_control_signals;
  logic [31:0] out_pc, out_pc_value_at_prediction;
  logic [2:0]  out_branch_sel;
  logic        out_branch_prediction;
  logic        cdb_valid_0, cdb_valid_1, cdb_valid_2;
  logic [31:0] cdb_data_0, cdb_data_1, cdb_data_2;

  tomasulo_dispatch_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_write(in_rd_write),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_is_store(in_is_store),
    .in_control_signals(in_control_signals), .in_pc(in_pc),
    .in_pc_value_at_prediction(in_pc_value_at_prediction),
    .in_branch_sel(in_branch_sel), .in_branch_prediction(in_branch_prediction),
    .rs_dispatch_valid(rs_dispatch_valid), .rs_dispatch_ready(rs_dispatch_ready),
    .out_operand_a_data(out_operand_a_data), .out_operand_b_data(out_operand_b_data),
    .out_store_data(out_store_data), .out_operand_a_tag(out_operand_a_tag),
    .out_operand_b_tag(out_operand_b_tag), .out_rd_phys_addr(out_rd_phys_addr),
    .out_control_signals(out_control_signals), .out_pc(out_pc),
    .out_pc_value_at_prediction(out_pc_value_at_prediction),
    .out_branch_sel(out_branch_sel), .out_branch_prediction(out_branch_prediction),
    .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1), .cdb_valid_2(cdb_valid_2),
    .cdb_data_0(cdb_data_0), .cdb_data_1(cdb_data_1), .cdb_data_2(cdb_data_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  v;
    logic [1:0]  at, bt;
    logic [31:0] ad, bd, sd, pc;
    logic [5:0]  rd;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   failures = 0;
  int   pc_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rs_dispatch_valid != 3'b000) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dispatch actual=%b required=none", rs_dispatch_valid);
      end else begin
        m_e = q.pop_front();
        chk({m_e.name, ".valid"}, 32'(rs_dispatch_valid), 32'(m_e.v));
        chk({m_e.name, ".a_tag"}, 32'(out_operand_a_tag), 32'(m_e.at));
        chk({m_e.name, ".a_data"}, out_operand_a_data, m_e.ad);
        chk({m_e.name, ".b_tag"}, 32'(out_operand_b_tag), 32'(m_e.bt));
        chk({m_e.name, ".b_data"}, out_operand_b_data, m_e.bd);
        chk({m_e.name, ".st_data"}, out_store_data, m_e.sd);
        chk({m_e.name, ".rd_phys"}, 32'(out_rd_phys_addr), 32'(m_e.rd));
        chk({m_e.name, ".pc"}, out_pc, m_e.pc);
        $display("dispatch %s rs=%b a=%0d/%h b=%0d/%h st=%h", m_e.name, rs_dispatch_valid,
                 out_operand_a_tag, out_operand_a_data, out_operand_b_tag,
                 out_operand_b_data, out_store_data);
      end
    end
  end

  task automatic clr();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_write = 0;
    in_use_imm = 0; in_imm = 0; in_is_store = 0; in_control_signals = 11'h5A5;
    in_pc = 0; in_pc_value_at_prediction = 32'hCAFE; in_branch_sel = 3'd2;
    in_branch_prediction = 0; rs_dispatch_ready = 3'b111;
    cdb_valid_0 = 0; cdb_valid_1 = 0; cdb_valid_2 = 0;
    cdb_data_0 = 0; cdb_data_1 = 0; cdb_data_2 = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic disp(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rdw, input logic use_imm, input logic [31:0] imm,
                      input logic st);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_write = rdw;
    in_use_imm = use_imm; in_imm = imm; in_is_store = st;
    in_pc = 32'h1000 + 32'(pc_n);
    pc_n++;
  endtask

  task automatic expect_d(input string nm, input logic [2:0] v, input logic [1:0] at,
                          input logic [31:0] ad, input logic [1:0] bt, input logic [31:0] bd,
                          input logic [31:0] sd);
    exp_t e;
    e.name = nm; e.v = v; e.at = at; e.ad = ad; e.bt = bt; e.bd = bd; e.sd = sd;
    e.rd = {1'b0, in_rd}; e.pc = in_pc;
    q.push_back(e);
  endtask

  task automatic ready_chk(input string nm, input logic req);
    #1;
    chk(nm, 32'(in_ready), 32'(req));
    $display("ready %s in_ready=%b", nm, in_ready);
  endtask

  // Reset, then confirm nothing strobes and previously tagged x1 reads ready.
  task automatic do_reset(input string nm);
    cyc(); reset = 1;
    cyc(); reset = 0;
    in_rs1 = 5'd1; in_rs2 = 5'd4;
    #1;
    chk({nm, ".rst_valid"}, 32'(rs_dispatch_valid), 32'h0);
    chk({nm, ".rst_a_tag"}, 32'(out_operand_a_tag), 32'h3);
    chk({nm, ".rst_b_tag"}, 32'(out_operand_b_tag), 32'h3);
    chk({nm, ".rst_ready"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    clr();
    reset = 1;
    do_reset("R0");
    // Basic dispatch and rr_ptr/tag update
    cyc(); disp(2, 3, 1, 1, 0, 0, 0); expect_d("A1_add", 3'b001, 3, 0, 3, 0, 0);
    cyc(); disp(1, 0, 4, 1, 0, 0, 0); expect_d("A2_dep", 3'b010, 0, 0, 3, 0, 0);
    do_reset("R1");
    // Dependent pair, CDB writeback
    cyc(); disp(0, 0, 5, 1, 0, 0, 0); expect_d("B1", 3'b001, 3, 0, 3, 0, 0);
    cyc(); disp(5, 0, 6, 1, 1, 4, 0); expect_d("B2_imm", 3'b010, 0, 0, 3, 4, 0);
    cyc(); cdb_valid_0 = 1; cdb_data_0 = 32'h1234;
    cyc(); disp(5, 0, 8, 1, 0, 0, 0); expect_d("B4_wb", 3'b100, 3, 32'h1234, 3, 0, 0);
    do_reset("R2");
    // Same-cycle bypass
    cyc(); disp(0, 0, 5, 1, 0, 0, 0); expect_d("C1", 3'b001, 3, 0, 3, 0, 0);
    cyc(); cdb_valid_0 = 1; cdb_data_0 = 32'hAA;
    disp(5, 5, 10, 1, 0, 0, 0); expect_d("C2_bypass", 3'b010, 3, 32'hAA, 3, 32'hAA, 32'hAA);
    do_reset("R3");
    // WAW
    cyc(); disp(0, 0, 7, 1, 0, 0, 0); expect_d("D1", 3'b001, 3, 0, 3, 0, 0);
    cyc(); disp(0, 0, 7, 1, 0, 0, 0); expect_d("D2", 3'b010, 3, 0, 3, 0, 0);
    cyc(); cdb_valid_0 = 1; cdb_data_0 = 32'h11;
    cyc(); disp(7, 0, 11, 1, 0, 0, 0); expect_d("D4_waw", 3'b100, 1, 0, 3, 0, 0);
    cyc(); cdb_valid_1 = 1; cdb_data_1 = 32'h55;
    cyc(); disp(7, 0, 12, 1, 0, 0, 0); expect_d("D6_waw", 3'b001, 3, 32'h55, 3, 0, 0);
    do_reset("R4");
    // Structural stall
    cyc(); disp(0, 0, 13, 1, 0, 0, 0); expect_d("E1", 3'b001, 3, 0, 3, 0, 0);
    cyc(); disp(0, 0, 14, 1, 0, 0, 0); expect_d("E2", 3'b010, 3, 0, 3, 0, 0);
    cyc(); disp(0, 0, 15, 1, 0, 0, 0); expect_d("E3", 3'b100, 3, 0, 3, 0, 0);
    cyc(); ready_chk("E4_full_idle", 1'b0);
    cyc(); disp(0, 0, 16, 1, 0, 0, 0); ready_chk("E5_full_valid", 1'b0);
    cyc(); disp(0, 0, 16, 1, 0, 0, 0); cdb_valid_1 = 1; cdb_data_1 = 32'h77;
    expect_d("E6_reuse", 3'b010, 3, 0, 3, 0, 0); ready_chk("E6_ready", 1'b1);
    do_reset("R5");
    // Store waiting on rs2, and x0 writes
    cyc(); disp(0, 0, 18, 1, 0, 0, 0); expect_d("F1", 3'b001, 3, 0, 3, 0, 0);
    cyc(); disp(0, 0, 19, 1, 0, 0, 0); expect_d("F2", 3'b010, 3, 0, 3, 0, 0);
    cyc(); disp(0, 0, 20, 1, 0, 0, 0); expect_d("F3", 3'b100, 3, 0, 3, 0, 0);
    cyc(); cdb_valid_0 = 1; cdb_data_0 = 32'h1; cdb_valid_1 = 1; cdb_data_1 = 32'h2;
    cyc(); disp(0, 20, 0, 0, 1, 8, 1); ready_chk("F5_store_wait", 1'b0);
    cyc(); disp(0, 20, 0, 0, 1, 8, 1); cdb_valid_2 = 1; cdb_data_2 = 32'h99;
    expect_d("F6_store", 3'b001, 3, 0, 3, 8, 32'h99);
    cyc(); disp(0, 0, 0, 1, 0, 0, 0); expect_d("F7_wr_x0", 3'b010, 3, 0, 3, 0, 0);
    cyc(); disp(0, 20, 21, 1, 0, 0, 0); expect_d("F8_x0", 3'b100, 3, 0, 3, 32'h99, 32'h99);
    cyc(); cdb_valid_1 = 1; cdb_data_1 = 32'hDEAD;
    cyc(); disp(0, 0, 22, 1, 0, 0, 0); expect_d("F10_x0", 3'b010, 3, 0, 3, 0, 0);
    cyc();
    cyc();
    chk("pending_dispatches", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
